// File: rtl/fpu_mul16_if.sv
// Request/response bundle between the FPU sequencer and the fp16 multiply unit.
// The master issues operands with start and receives the product, its condition codes and done.
interface fpu_mul16_if;
    logic        start;
    logic [15:0] fpuIn1;
    logic [15:0] fpuIn2;
    logic [15:0] fpuOut;
    logic        done;
    logic [3:0]  condCodes;

    modport master (
        output start,
        output fpuIn1,
        output fpuIn2,
        input  fpuOut,
        input  done,
        input  condCodes
    );

    modport slave (
        input  start,
        input  fpuIn1,
        input  fpuIn2,
        output fpuOut,
        output done,
        output condCodes
    );
endinterface

// File: rtl/fpu_mul16.sv
// Sequential IEEE-754 binary16 multiplier: MUL -> NORM -> ROUND -> DONE, round to nearest even.
// Subnormal operands and underflowing results flush to signed zero; condCodes are {Z, C, N, V}.
module fpu_mul16 (
    input  logic        clock,
    input  logic        reset,
    fpu_mul16_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

    localparam logic [15:0] QNAN = 16'h7E00;

    // {0, 1.frac} plus the round-to-nearest-even increment; bit 11 set means it carried into 2.0
    function automatic logic [11:0] rne_round(input logic [20:0] m, input logic stky);
        logic guard;
        logic rest;
        logic up;
        guard = m[9];
        rest  = (|m[8:0]) | stky;
        up    = guard & (rest | m[10]);
        return {1'b0, m[20:10]} + {11'b0, up};
    endfunction

    function automatic logic is_inexact(input logic [9:0] low, input logic stky);
        return (|low) | stky;
    endfunction

    // Saturates to infinity or flushes to zero; returns {condCodes, fpuOut}
    function automatic logic [19:0] sat_pack(input logic sgn, input logic signed [7:0] e,
                                             input logic [9:0] frac, input logic inx);
        if (e >= 8'sd31)
            return {1'b0, 1'b1, sgn, 1'b1, sgn, 5'h1F, 10'h000};
        else if (e <= 8'sd0)
            return {1'b1, 1'b1, sgn, 1'b0, sgn, 15'h0000};
        else
            return {1'b0, inx, sgn, 1'b0, sgn, e[4:0], frac};
    endfunction

    state_t state, state_nxt;

    logic [15:0] opa_p0, opb_p0;
    logic [15:0] out_r;
    logic [3:0]  cc_r;
    logic        done_r;

    logic               sign_p1;
    logic signed [7:0]  exp_p1;
    logic [21:0]        prod_p1;
    spec_t              spec_p1;

    logic               sign_p2;
    logic signed [7:0]  exp_p2;
    logic [20:0]        mant_p2;
    logic               stky_p2;
    spec_t              spec_p2;

    logic               sign_mul;
    logic signed [7:0]  exp_mul;
    logic [21:0]        prod_mul;
    spec_t              spec_mul;

    logic [11:0]        sig_rnd;
    logic signed [7:0]  exp_rnd;
    logic [9:0]         frac_rnd;
    logic               inx_rnd;
    logic [19:0]        res_rnd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = MUL;
            MUL:     state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Classification and significand product from the latched operands
    always_comb begin
        logic [4:0] ea, eb;
        logic [9:0] fa, fb;
        logic nan_a, nan_b, inf_a, inf_b, zro_a, zro_b;
        ea = opa_p0[14:10];
        eb = opb_p0[14:10];
        fa = opa_p0[9:0];
        fb = opb_p0[9:0];
        nan_a = (&ea) & (|fa);
        nan_b = (&eb) & (|fb);
        inf_a = (&ea) & ~(|fa);
        inf_b = (&eb) & ~(|fb);
        zro_a = ~(|ea);
        zro_b = ~(|eb);

        sign_mul = opa_p0[15] ^ opb_p0[15];
        exp_mul  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
        prod_mul = 22'({1'b1, fa}) * 22'({1'b1, fb});

        spec_mul = SP_NONE;
        if (nan_a || nan_b || (inf_a && zro_b) || (inf_b && zro_a))
            spec_mul = SP_NAN;
        else if (inf_a || inf_b)
            spec_mul = SP_INF;
        else if (zro_a || zro_b)
            spec_mul = SP_ZERO;
    end

    always_comb begin
        sig_rnd  = rne_round(mant_p2, stky_p2);
        exp_rnd  = exp_p2;
        frac_rnd = sig_rnd[9:0];
        if (sig_rnd[11]) begin
            exp_rnd  = exp_p2 + 8'sd1;
            frac_rnd = sig_rnd[10:1];
        end
        inx_rnd = is_inexact(mant_p2[9:0], stky_p2);

        case (spec_p2)
            SP_NAN:  res_rnd = {4'b0000, QNAN};
            SP_INF:  res_rnd = {1'b0, 1'b0, sign_p2, 1'b0, sign_p2, 5'h1F, 10'h000};
            SP_ZERO: res_rnd = {1'b1, 1'b0, sign_p2, 1'b0, sign_p2, 15'h0000};
            default: res_rnd = sat_pack(sign_p2, exp_rnd, frac_rnd, inx_rnd);
        endcase
    end

    // Stage p0: operand capture; outputs register on the edge into DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opa_p0 <= 16'h0000;
            opb_p0 <= 16'h0000;
            out_r  <= 16'h0000;
            cc_r   <= 4'b0000;
            done_r <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                opa_p0 <= bus.fpuIn1;
                opb_p0 <= bus.fpuIn2;
            end
            if (state == ROUND) begin
                out_r <= res_rnd[15:0];
                cc_r  <= res_rnd[19:16];
            end
            done_r <= (state_nxt == DONE);
        end
    end

    // Stage p1 (MUL) and p2 (NORM): right-shift by one when the product reached [2,4)
    always_ff @(posedge clock) begin
        if (state == MUL) begin
            sign_p1 <= sign_mul;
            exp_p1  <= exp_mul;
            prod_p1 <= prod_mul;
            spec_p1 <= spec_mul;
        end
        if (state == NORM) begin
            sign_p2 <= sign_p1;
            spec_p2 <= spec_p1;
            if (prod_p1[21]) begin
                mant_p2 <= prod_p1[21:1];
                stky_p2 <= prod_p1[0];
                exp_p2  <= exp_p1 + 8'sd1;
            end else begin
                mant_p2 <= prod_p1[20:0];
                stky_p2 <= 1'b0;
                exp_p2  <= exp_p1;
            end
        end
    end

    assign bus.fpuOut    = out_r;
    assign bus.condCodes = cc_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_fpu_mul16.sv
// Directed-vector bench for fpu_mul16: arithmetic, rounding, special operands and control corners.
// Expected products and condition codes {Z, C, N, V} are hand-computed.
module tb_fpu_mul16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fpu_mul16_if bus();

    fpu_mul16 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at a negedge, count edges until done, then check result and pulse width
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eo, input logic [3:0] ec);
        int n;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.fpuIn1 = a;
        bus.fpuIn2 = b;
        @(posedge clock);
        n = 1;
        @(negedge clock);
        bus.start  = 1'b0;
        bus.fpuIn1 = 16'hDEAD;
        bus.fpuIn2 = 16'hBEEF;
        while (!bus.done && n < 10) begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        chk({tag, " latency"}, n, 4);
        chk({tag, " out"}, {16'h0, bus.fpuOut}, {16'h0, eo});
        chk({tag, " cc"}, {28'h0, bus.condCodes}, {28'h0, ec});
        @(negedge clock);
        chk({tag, " pulse"}, {31'h0, bus.done}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dcnt;
        bus.start  = 1'b0;
        bus.fpuIn1 = 16'h0000;
        bus.fpuIn2 = 16'h0000;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset out", {16'h0, bus.fpuOut}, 32'h0);
        chk("reset cc", {28'h0, bus.condCodes}, 32'h0);
        chk("reset done", {31'h0, bus.done}, 32'h0);
        reset = 1'b1;

        run_op("1x1",      16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);
        run_op("12x9",     16'h4A00, 16'h4880, 16'h56C0, 4'b0000);
        run_op("neg",      16'hCB00, 16'h5770, 16'hE682, 4'b0010);
        run_op("normrnd",  16'h4B48, 16'h47D5, 16'h5721, 4'b0100);
        run_op("tie_odd",  16'h3C01, 16'h3E00, 16'h3E02, 4'b0100);
        run_op("tie_even", 16'h3C03, 16'h3E00, 16'h3E04, 4'b0100);
        run_op("rndcarry", 16'h3DA9, 16'h3DA7, 16'h4000, 4'b0100);
        run_op("infx0",    16'h7C00, 16'h0000, 16'h7E00, 4'b0000);
        run_op("nan",      16'h7C01, 16'h3C00, 16'h7E00, 4'b0000);
        run_op("ovf",      16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);
        run_op("ninf",     16'hFC00, 16'h3C00, 16'hFC00, 4'b0010);
        run_op("negzero",  16'h8000, 16'h3C00, 16'h8000, 4'b1010);
        run_op("subnorm",  16'h0001, 16'h3C00, 16'h0000, 4'b1000);
        run_op("unf",      16'h0400, 16'h0400, 16'h0000, 4'b1100);

        // start pulsed while in MUL must not disturb the running operation
        @(negedge clock);
        bus.start  = 1'b1;
        bus.fpuIn1 = 16'h3C00;
        bus.fpuIn2 = 16'h4000;
        @(posedge clock);
        n = 1;
        @(negedge clock);
        bus.fpuIn1 = 16'h4200;
        bus.fpuIn2 = 16'h4200;
        @(posedge clock);
        n++;
        @(negedge clock);
        bus.start = 1'b0;
        while (!bus.done && n < 10) begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        chk("ignore latency", n, 4);
        chk("ignore out", {16'h0, bus.fpuOut}, 32'h4000);
        dcnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.done) dcnt++;
        end
        chk("ignore no 2nd done", dcnt, 0);

        // asynchronous reset while in NORM aborts with cleared outputs
        @(negedge clock);
        bus.start  = 1'b1;
        bus.fpuIn1 = 16'h4A00;
        bus.fpuIn2 = 16'h4880;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort out", {16'h0, bus.fpuOut}, 32'h0);
        chk("abort cc", {28'h0, bus.condCodes}, 32'h0);
        chk("abort done", {31'h0, bus.done}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        dcnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.done) dcnt++;
        end
        chk("abort no done", dcnt, 0);

        run_op("after abort", 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_mul16.md
Name:
fpu_mul16

Overview:
- Sequential IEEE-754 binary16 (half-precision) multiplier used as the multiply unit of the FPU.
- Captures two fp16 operands on `start` and runs a short multi-cycle state machine: significand multiply, normalize, round-to-nearest-even, pack.
- Presents the product and condition codes with a one-cycle `done` pulse.

Parameters:
- None. Format is fixed: 1 sign, 5 exponent (bias 15), 10 fraction bits.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- fpuIn1  in  16  operand A, fp16_t
- fpuIn2  in  16  operand B, fp16_t
- fpuOut  out  16  product, fp16_t
- done  out  1  one-cycle pulse when fpuOut/condCodes are valid
- condCodes  out  4  {Z, C, N, V}: Z result zero; C inexact (rounding discarded nonzero bits); N sign of result; V overflow to infinity

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; fpuOut=16'h0000; condCodes=4'b0000; done=0; internal operand registers cleared.
  - Deassertion takes effect on the next clock edge.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states and transitions: IDLE -> MUL -> NORM -> ROUND -> DONE -> IDLE.
  - IDLE: when start=1 at a rising edge, latch fpuIn1/fpuIn2 and go to MUL. Otherwise stay in IDLE.
  - MUL: sign = sA^sB. unnormExp = eA+eB-15, held with at least 7 bits signed. 22-bit product = {1,fA}*{1,fB}. Internal split: sigMulOutInt = top 2 bits, sigMulOutFrac = low 20 bits.
  - NORM: if sigMulOutInt[1]=1, shift right by 1 and increment the exponent.
  - ROUND: keep a 10-bit fraction; guard/sticky from the discarded bits. Round to nearest, ties to even. A rounding carry into 2.0 renormalizes and increments the exponent.
  - DONE: register fpuOut and condCodes, assert done for exactly this cycle, return to IDLE.
- Latency: done is high 4 clock edges after the edge that samples start.
- fpuOut and condCodes hold their values until the next DONE or reset.
- start asserted outside IDLE is ignored. start held high in IDLE after DONE begins a new operation.
- Inputs are don't-care after the latching edge.
- Special cases, resolved before the normal path; timing is unchanged, still passing through all states:
  - Either input NaN, or inf*0 -> 16'h7E00 (canonical qNaN); condCodes=0000.
  - inf*finite-nonzero -> signed infinity; N set, V=0.
  - Either input zero or subnormal (exp=0) -> subnormals are flushed to zero; result is signed zero (sign = sA^sB); Z=1, N=sign.
  - Final exponent >= 31 -> signed infinity; V=1, C=1.
  - Final exponent <= 0 -> flush to signed zero; Z=1, C=1.
- N = result sign bit for all non-NaN results, including -0.

Test Plan:
- 3C00 * 3C00 (1*1) -> fpuOut=3C00, condCodes Z=0 C=0 N=0 V=0; done exactly 4 edges after start.
- 4A00 * 4880 (12*9) -> 56C0 (108); C=0, N=0.
- CB00 * 5770 (-14*119) -> E682 (-1666); N=1, C=0.
- 4B48 * 47D5 (14.5625*7.83203125) -> 5721; normalization shift taken, round up, C=1.
- Specials:
  - 7C00 * 0000 -> 7E00.
  - 7BFF * 7BFF -> 7C00, V=1.
  - 8000 * 3C00 -> 8000, Z=1, N=1.
  - 0001 * 3C00 -> 0000, Z=1.
- Control:
  - start pulsed during MUL is ignored.
  - reset low during NORM -> outputs 0, no done.
  - The next start completes normally.
